// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receiver: parity modes, receiver FSM states,
// the stored frame record and the parity helper.
package uart_pkg;

    localparam int RX_DATA_W = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic [RX_DATA_W-1:0] data;
        logic                 perr;
        logic                 ferr;
    } rx_frame_t;

    // Parity bit the transmitter should have sent for the given data word.
    // Data narrower than 9 bits is zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic [8:0] data, input parity_e mode);
        logic x;
        x = ^data;
        return (mode == ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Ready/valid output stream of the UART receiver FIFO.
// master: the receiver driving head-of-FIFO data; slave: the consumer.
interface uart_rx_fifo_if #(
    parameter int BITS_N = 8
);
    logic [BITS_N-1:0] data_out;
    logic              parity_error;
    logic              framing_error;
    logic              valid_out;
    logic              ready_in;

    modport master (
        output data_out,
        output parity_error,
        output framing_error,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  parity_error,
        input  framing_error,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous show-ahead FIFO with occupancy count.
// A write while full is accepted only if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, oversampled 3-sample majority
// vote, optional parity, 1/2 stop bits, framing-error and break detection,
// feeding a show-ahead frame FIFO with ready/valid output.
// Optional idle-timeout feature: define UART_RX_TIMEOUT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BITS_N      = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          uart_in,
    uart_rx_fifo_if.master                rx_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    output logic                          rx_idle_timeout
);
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int CNT_W   = 4;
    localparam int FRAME_W = $bits(rx_frame_t) - RX_DATA_W + BITS_N;
    localparam bit PAR_EN  = (PARITY_TYPE != 0);
    localparam parity_e PAR_MODE = parity_e'(2'(PARITY_TYPE));

    localparam logic [OS_W-1:0]  OS_S0     = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0]  OS_S1     = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0]  OS_S2     = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITS_N - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    logic               rx_meta, rx_s, rx_prev;
    logic [DIV_W-1:0]   div_q, tick_cnt;
    logic               tick, mid_tick, end_tick;
    logic [OS_W-1:0]    os_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic               s0, s1, samp;
    logic [BITS_N-1:0]  data_sh;
    logic               par_bit, ferr_q, perr_now, is_break;
    rx_state_e          state, state_n;
    logic               start_go, shift_en, par_smp, stop_smp, frame_done;
    logic               push_now, brk_now;
    logic               push_vld_p1;
    logic [FRAME_W-1:0] frame_p1;
    logic [FRAME_W-1:0] head;
    logic               fifo_full, fifo_empty, pop;

    assign tick     = (tick_cnt == div_q);
    assign mid_tick = tick && (os_cnt == OS_S2);
    assign end_tick = tick && (os_cnt == OS_LAST);
    assign samp     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign is_break = (data_sh == '0) && (!PAR_EN || !par_bit) && !samp;
    assign perr_now = PAR_EN && (par_bit != parity_calc(9'(data_sh), PAR_MODE));
    assign pop      = rx_o.ready_in & ~fifo_empty;

    // Two-flop synchroniser plus previous-value flop for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Oversample tick generator; divisor is frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (start_go) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (rx_prev && !rx_s) state_n = START;
            START:    if (mid_tick && samp) state_n = IDLE;
                      else if (end_tick)    state_n = DATA;
            DATA:     if (end_tick && bit_cnt == BIT_LAST)
                          state_n = PAR_EN ? PARITY : STOP;
            PARITY:   if (end_tick) state_n = STOP;
            STOP:     if (mid_tick && bit_cnt == STOP_LAST)
                          state_n = (is_break || ferr_q || !samp) ? BRK_WAIT : IDLE;
            BRK_WAIT: if (tick && rx_s && os_cnt == OS_LAST) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // FSM outputs: per-state sampling strobes and end-of-frame decisions.
    always_comb begin
        start_go   = 1'b0;
        shift_en   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:    start_go = rx_prev & ~rx_s;
            DATA:    shift_en = mid_tick;
            PARITY:  par_smp  = mid_tick;
            STOP: begin
                stop_smp   = mid_tick;
                frame_done = mid_tick && (bit_cnt == STOP_LAST);
            end
            default: ;
        endcase
        push_now = frame_done & ~is_break;
        brk_now  = frame_done &  is_break;
    end

    // Oversample/bit counters; BRK_WAIT reuses os_cnt to time a full high bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
        end else if (state_n != state) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
        end else if (tick) begin
            if (os_cnt == OS_LAST || (state == BRK_WAIT && !rx_s)) os_cnt <= '0;
            else                                                   os_cnt <= os_cnt + 1'b1;
            if (end_tick && (state == DATA || state == STOP))      bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Sample capture and frame assembly (data path, no reset).
    always_ff @(posedge clk) begin
        if (tick && os_cnt == OS_S0) s0 <= rx_s;
        if (tick && os_cnt == OS_S1) s1 <= rx_s;
        if (shift_en) data_sh <= {samp, data_sh[BITS_N-1:1]};
        if (par_smp)  par_bit <= samp;
        if (start_go)                ferr_q <= 1'b0;
        else if (stop_smp && !samp)  ferr_q <= 1'b1;
        if (push_now) frame_p1 <= {data_sh, perr_now, ferr_q | ~samp};
    end

    // Stage p1: push strobe, break and overrun pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_vld_p1 <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            push_vld_p1 <= push_now;
            break_det   <= brk_now;
            overrun     <= push_vld_p1 & fifo_full & ~pop;
        end
    end

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_vld_p1),
        .wr_data (frame_p1),
        .rd_en   (rx_o.ready_in),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rx_o.valid_out     = ~fifo_empty;
    assign rx_o.data_out      = fifo_empty ? '0 : head[FRAME_W-1:2];
    assign rx_o.parity_error  = ~fifo_empty & head[1];
    assign rx_o.framing_error = ~fifo_empty & head[0];

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = 4 * (1 + BITS_N + (PAR_EN ? 1 : 0) + STOP_BITS) * OVERSAMPLE;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt;

    // Idle timeout: count ticks in IDLE with data waiting, saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt          <= '0;
            rx_idle_timeout <= 1'b0;
        end else begin
            rx_idle_timeout <= 1'b0;
            if (start_go || pop) begin
                to_cnt <= '0;
            end else if (state == IDLE && !fifo_empty && tick && to_cnt != TO_W'(TO_LIMIT)) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_W'(TO_LIMIT - 1)) rx_idle_timeout <= 1'b1;
            end
        end
    end
`else
    assign rx_idle_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (even parity, 1 stop bit, 16x oversampling, depth 8).
module tb_uart_rx_fifo;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd26;
    logic        uart_in = 1'b1;
    logic [3:0]  fifo_count;
    logic        overrun, break_det, rx_idle_timeout;

    uart_rx_fifo_if #(.BITS_N(8)) rx_if ();

    uart_rx_fifo #(
        .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1),
        .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_div        (baud_div),
        .uart_in         (uart_in),
        .rx_o            (rx_if.master),
        .fifo_count      (fifo_count),
        .overrun         (overrun),
        .break_det       (break_det),
        .rx_idle_timeout (rx_idle_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;

    always @(negedge clk) begin
        if (overrun)   ovr_cnt++;
        if (break_det) brk_cnt++;
    end

    typedef struct {
        logic [7:0] d;
        logic       par_bad;
        logic       stop;
        int         div;
        logic [7:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t model_q[$];
    int   exp_ovr;
    int   exp_brk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return 1'($countones(d) % 2);
    endfunction

    task automatic drive_bit(input logic b, input int div);
        uart_in = b;
        repeat (OS * (div + 1)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int div);
        @(negedge clk);
        baud_div = 16'(div);
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
        drive_bit(par, div);
        drive_bit(stop, div);
        drive_bit(1'b1, div);
        drive_bit(1'b1, div);
    endtask

    task automatic pop_one();
        rx_if.ready_in = 1'b1;
        @(negedge clk);
        rx_if.ready_in = 1'b0;
    endtask

    // Reference: what the receiver should store for a frame on the wire.
    task automatic model_send(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        if (d == 8'h00 && !par && !stop) begin
            exp_brk++;
        end else if (model_q.size() == 8) begin
            exp_ovr++;
        end else begin
            e.d    = d;
            e.perr = (($countones(d) + int'(par)) % 2) != 0;
            e.ferr = !stop;
            model_q.push_back(e);
        end
    endtask

    task automatic drain_model(input string tag);
        exp_t e;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            check({tag, "_valid"}, 32'(rx_if.valid_out), 32'd1);
            check({tag, "_data"},  32'(rx_if.data_out), 32'(e.d));
            check({tag, "_perr"},  32'(rx_if.parity_error), 32'(e.perr));
            check({tag, "_ferr"},  32'(rx_if.framing_error), 32'(e.ferr));
            pop_one();
        end
        check({tag, "_empty"}, 32'(fifo_count), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int b0, o0, n;
        logic [7:0] d;
        logic p, s;
        int dv;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 26, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 26, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1,  8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 0,  8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 2,  8'h55, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 3,  8'h81, 1'b0, 1'b0};

        rx_if.ready_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid",   32'(rx_if.valid_out), 32'd0);
        check("rst_data",    32'(rx_if.data_out), 32'd0);
        check("rst_perr",    32'(rx_if.parity_error), 32'd0);
        check("rst_ferr",    32'(rx_if.framing_error), 32'd0);
        check("rst_count",   32'(fifo_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_break",   32'(break_det), 32'd0);

        // Table-driven single frames, each popped after checking.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].d, even_par(vecs[i].d) ^ vecs[i].par_bad, vecs[i].stop, vecs[i].div);
            check($sformatf("vec%0d_valid", i), 32'(rx_if.valid_out), 32'd1);
            check($sformatf("vec%0d_data", i),  32'(rx_if.data_out), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_perr", i),  32'(rx_if.parity_error), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i),  32'(rx_if.framing_error), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
            pop_one();
            check($sformatf("vec%0d_popcnt", i), 32'(fifo_count), 32'd0);
            check($sformatf("vec%0d_popvld", i), 32'(rx_if.valid_out), 32'd0);
        end

        // Framing error followed by a break: break pulses once, FIFO untouched.
        send_frame(8'h55, even_par(8'h55), 1'b0, 2);
        check("fe_ferr",  32'(rx_if.framing_error), 32'd1);
        check("fe_data",  32'(rx_if.data_out), 32'h55);
        b0 = brk_cnt;
        @(negedge clk);
        uart_in = 1'b0;
        repeat (12 * OS * 3) @(negedge clk);
        uart_in = 1'b1;
        repeat (3 * OS * 3) @(negedge clk);
        check("brk_pulses", 32'(brk_cnt - b0), 32'd1);
        check("brk_count",  32'(fifo_count), 32'd1);
        check("brk_data",   32'(rx_if.data_out), 32'h55);
        pop_one();

        // Short low glitch is a false start: nothing stored, next frame intact.
        b0 = brk_cnt;
        o0 = ovr_cnt;
        baud_div = 16'd2;
        uart_in = 1'b0;
        repeat (4 * 3) @(negedge clk);
        uart_in = 1'b1;
        repeat (2 * OS * 3) @(negedge clk);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_valid", 32'(rx_if.valid_out), 32'd0);
        check("glitch_brk",   32'(brk_cnt - b0), 32'd0);
        check("glitch_ovr",   32'(ovr_cnt - o0), 32'd0);
        send_frame(8'h5A, even_par(8'h5A), 1'b1, 2);
        check("post_glitch_data", 32'(rx_if.data_out), 32'h5A);
        check("post_glitch_cnt",  32'(fifo_count), 32'd1);
        pop_one();

        // Overflow: nine frames with the consumer stalled.
        o0 = ovr_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), even_par(8'(i)), 1'b1, 0);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_pulses", 32'(ovr_cnt - o0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), 32'(rx_if.data_out), 32'(i));
            pop_one();
        end
        check("ovf_empty", 32'(fifo_count), 32'd0);

        // Reset mid-frame discards both the FIFO and the partial frame.
        send_frame(8'h11, even_par(8'h11), 1'b1, 2);
        @(negedge clk);
        baud_div = 16'd2;
        drive_bit(1'b0, 2);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 2);
        rst = 1'b1;
        uart_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(rx_if.valid_out), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        repeat (2 * OS * 3) @(negedge clk);
        send_frame(8'h81, even_par(8'h81), 1'b1, 2);
        check("midrst_next_data", 32'(rx_if.data_out), 32'h81);
        check("midrst_next_perr", 32'(rx_if.parity_error), 32'd0);
        check("midrst_next_cnt",  32'(fifo_count), 32'd1);
        pop_one();

        // Randomised bursts against the reference model.
        for (int burst = 0; burst < 4; burst++) begin
            exp_ovr = 0;
            exp_brk = 0;
            o0 = ovr_cnt;
            b0 = brk_cnt;
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                d  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) d = 8'h00;
                p  = even_par(d) ^ ($urandom_range(0, 3) == 0);
                s  = ($urandom_range(0, 4) != 0);
                dv = $urandom_range(0, 2);
                model_send(d, p, s);
                send_frame(d, p, s, dv);
            end
            check($sformatf("rnd%0d_count", burst), 32'(fifo_count), 32'(model_q.size()));
            check($sformatf("rnd%0d_ovr", burst), 32'(ovr_cnt - o0), 32'(exp_ovr));
            check($sformatf("rnd%0d_brk", burst), 32'(brk_cnt - b0), 32'(exp_brk));
            drain_model($sformatf("rnd%0d", burst));
        end

        check("timeout_off", 32'(rx_idle_timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor UART receiver for the WiFi-module link. Adds runtime baud divisor, 16x oversampling with 3-sample majority vote, configurable parity and stop bits, framing-error and break detection. Received frames are buffered in a show-ahead FIFO with a ready/valid output, so the consumer can stall without losing bytes.

Parameters:
BITS_N, 8, data bits per frame (5..9).
PARITY_TYPE, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked (1 or 2).
OVERSAMPLE, 16, oversample ticks per bit (even, >=8).
DIV_W, 16, width of baud_div.
FIFO_DEPTH, 8, frame FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous active-high reset
baud_div  in  DIV_W  clk cycles per oversample tick minus 1
uart_in  in  1  asynchronous serial line, idle high
data_out  out  BITS_N  head-of-FIFO data
parity_error  out  1  parity flag stored with head frame
framing_error  out  1  stop-bit flag stored with head frame
valid_out  out  1  FIFO non-empty
ready_in  in  1  consumer accepts head when valid_out
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overrun  out  1  one-cycle pulse: frame dropped, FIFO full
break_det  out  1  one-cycle pulse: break condition detected
rx_idle_timeout  out  1  see Optional Feature

Behaviour:
- Reset (synchronous, active-high): synchroniser flops to 1, FSM to IDLE, tick counter 0, FIFO emptied. All outputs 0, including data_out. Reset mid-frame discards the partial frame.
- uart_in passes through a 2-flop synchroniser. All logic uses the synchronised signal rx_s.
- Tick generator: counter 0..div_q. tick asserts for one cycle when the counter equals div_q. div_q==0 gives a tick every cycle. div_q latches baud_div on the IDLE->START transition and holds for the frame.
- Bit sample = majority of rx_s at ticks OVERSAMPLE/2-1, /2, /2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE->START on rx_s falling edge; tick counter and oversample counter reset.
  - START: at mid-bit, sample 1 is a false start -> IDLE; sample 0 -> DATA.
  - DATA: BITS_N samples, LSB first, one per OVERSAMPLE ticks.
  - DATA -> PARITY if PARITY_TYPE!=0, else -> STOP.
  - PARITY: parity_err = XOR(data, bit) mismatched against the mode.
  - STOP: STOP_BITS samples. Any 0 sets ferr.
  - At the last stop-bit mid-sample:
    - Break (all data bits 0, parity bit 0 if present, stop 0): break_det pulses, no push, -> BRK_WAIT.
    - Otherwise push {data, perr, ferr}. If ferr -> BRK_WAIT, else -> IDLE.
  - BRK_WAIT -> IDLE once rx_s has been 1 for one full bit time.
- Latency: push on the cycle after the final stop-bit sample tick. valid_out rises the next cycle when the FIFO was empty.
- FIFO: show-ahead. Pop when valid_out && ready_in.
  - Push when full without a same-cycle pop: frame dropped, overrun pulses, contents unchanged.
  - Push and pop in the same cycle when full: both occur, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined: a counter of oversample ticks runs in IDLE while the FIFO is non-empty. It clears on any start bit or pop. rx_idle_timeout pulses once when the counter reaches 4*(1+BITS_N+(PARITY_TYPE!=0)+STOP_BITS)*OVERSAMPLE, then holds until cleared.
- Undefined: rx_idle_timeout is tied 0 and no counter is built.

Decomposition:
- Package uart_pkg: parity_e (NONE, ODD, EVEN), rx_state_e, rx_frame_t struct {data, perr, ferr} (BITS_N from a package localparam default), function parity_calc.
- Sub-module sync_fifo (generic WIDTH/DEPTH, show-ahead, count output), instantiated with rx_frame_t width.

Test Plan:
- Reset, baud_div=26, PARITY_TYPE=2, send 0xA5 with parity bit 0 -> data_out=0xA5, parity_error=0, framing_error=0, fifo_count=1.
- Send 0x3C with parity bit 1 (wrong) -> data_out=0x3C, parity_error=1. Pop, then fifo_count=0 and valid_out=0.
- ready_in=0, send 0x00..0x08 (9 frames), FIFO_DEPTH=8 -> fifo_count=8, overrun pulses once on the 9th frame. Draining yields 0x00..0x07 in order.
- Send 0x55 with stop bit 0 -> framing_error=1 with data 0x55. Then hold line low for 12 bit times -> one break_det pulse, fifo_count unchanged.
- Low glitch of 4 oversample ticks, then high -> no push, FSM back in IDLE, no flags.
- Assert rst after 4 data bits of 0xF0 -> valid_out=0, fifo_count=0. Next frame 0x81 is received correctly.
